// File: rtl/bram_access_arbiter.sv
// Shares one single-port BRAM between a write loader and N_RD round-robin read lanes.
// Writes normally win; a saturating starvation counter forces a read through.
module bram_access_arbiter #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 784,
  parameter int DEPTH_BITS   = 10,
  parameter int N_RD         = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_req,
  input  logic [DEPTH_BITS-1:0]      wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_gnt,
  input  logic [N_RD-1:0]            rd_req,
  input  logic [N_RD*DEPTH_BITS-1:0] rd_addr,
  output logic [N_RD-1:0]            rd_gnt,
  output logic [N_RD-1:0]            rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       ram_write_en,
  output logic [DEPTH_BITS-1:0]      ram_write_address,
  output logic [WIDTH-1:0]           ram_write_data_in,
  output logic                       ram_read_en,
  output logic [DEPTH_BITS-1:0]      ram_read_address,
  input  logic [WIDTH-1:0]           ram_read_data_out
);

  localparam int PTR_W = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int CW    = PTR_W + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  if (DEPTH > (1 << DEPTH_BITS)) begin : g_depth_check
    $error("DEPTH does not fit in DEPTH_BITS");
  end
  if (N_RD < 2 || N_RD > 8) begin : g_nrd_check
    $error("N_RD must be in 2..8");
  end

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [N_RD-1:0]  rd_valid_q;

  logic             rd_any;
  logic             force_rd;
  logic             rd_hit;
  logic             rd_granted;
  logic [PTR_W-1:0] rd_lane;
  logic [CW-1:0]    cand;

  assign rd_any   = |rd_req;
  assign force_rd = rd_any && (starve_q == CNT_W'(STARVE_LIMIT));
  assign wr_gnt   = !rst && wr_req && !force_rd;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : rr_scan
    rd_hit  = 1'b0;
    rd_lane = '0;
    cand    = '0;
    for (int i = 0; i < N_RD; i++) begin
      cand = CW'(rr_ptr_q) + CW'(i);
      if (cand >= CW'(N_RD)) cand = cand - CW'(N_RD);
      if (!rd_hit && rd_req[cand[PTR_W-1:0]]) begin
        rd_hit  = 1'b1;
        rd_lane = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin : rd_grant
    rd_gnt = '0;
    if (!rst && rd_hit && !wr_gnt) rd_gnt[rd_lane] = 1'b1;
  end

  assign rd_granted = |rd_gnt;

  always_comb begin : next_state
    starve_d = starve_q;
    rr_ptr_d = rr_ptr_q;
    if (rd_granted || !rd_any) starve_d = '0;
    else if (wr_gnt && starve_q != CNT_W'(STARVE_LIMIT)) starve_d = starve_q + CNT_W'(1);
    if (rd_granted) rr_ptr_d = (rd_lane == PTR_W'(N_RD - 1)) ? '0 : rd_lane + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      starve_q   <= '0;
      rd_valid_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      starve_q   <= starve_d;
      rd_valid_q <= rd_gnt;
    end
  end

  assign ram_write_en      = wr_gnt;
  assign ram_write_address = wr_addr;
  assign ram_write_data_in = wr_data;
  assign ram_read_en       = rd_granted;
  assign ram_read_address  = rd_granted ? rd_addr[int'(rd_lane)*DEPTH_BITS +: DEPTH_BITS] : '0;
  assign rd_valid          = rd_valid_q;
  assign rd_data           = ram_read_data_out;

endmodule
